// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and default sizing for the posted-write buffer.
//                - wb_state_t : read-path controller states
//                - wb_entry_t : one buffered store {word address, data}
//  Revision    : 1.0  initial release
// ============================================================================
package wb_pkg;

    localparam int unsigned c_DEPTH_DEFAULT    = 4;
    localparam int unsigned c_READ_LAT_DEFAULT = 2;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/write_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : write_buffer_if
//  Description : CPU-side and memory-side bus of the write buffer.
//                slave  : view used by write_buffer
//                master : view used by the CPU / memory environment
//                CPU    : cpu_req, cpu_wr, cpu_addr, cpu_wdata -> buffer
//                         cpu_rdata, cpu_stall                 <- buffer
//                Memory : mem_addr, mem_wr, mem_wdata           <- buffer
//                         mem_rdata                             -> buffer
//                Status : wb_empty, wb_count                    <- buffer
//  Revision    : 1.0  initial release
// ============================================================================
interface write_buffer_if #(
    parameter int DEPTH = 4
) ();
    logic                     cpu_req;
    logic                     cpu_wr;
    logic [31:0]              cpu_addr;
    logic [31:0]              cpu_wdata;
    logic [31:0]              cpu_rdata;
    logic                     cpu_stall;
    logic [31:0]              mem_addr;
    logic                     mem_wr;
    logic [31:0]              mem_wdata;
    logic [31:0]              mem_rdata;
    logic                     wb_empty;
    logic [$clog2(DEPTH):0]   wb_count;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_stall, mem_addr, mem_wr, mem_wdata,
               wb_empty, wb_count
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_stall, mem_addr, mem_wr, mem_wdata,
               wb_empty, wb_count
    );
endinterface
`default_nettype wire

// File: rtl/write_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : write_buffer_fifo
//  Description : Circular store FIFO for the write buffer.
//                clock, reset   : clock / synchronous active-high reset
//                push, push_entry : enqueue at tail (caller guarantees !full)
//                pop            : dequeue head (caller guarantees !empty)
//                head_entry     : oldest entry
//                ent, ent_valid : all slots ordered newest-first (index 0 is
//                                 the most recent store) for forwarding
//                count, full, empty : registered occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module write_buffer_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    output wb_entry_t               head_entry,
    output logic [DEPTH-1:0]        ent_valid,
    output wb_entry_t [DEPTH-1:0]   ent,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem_q [DEPTH];
    wb_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[tail_q] = push_entry;
        end
        // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Slot g of the view is the (g+1)-th most recent store: tail-1-g.
    for (genvar g = 0; g < DEPTH; g++) begin : g_view
        wire logic [PTR_W-1:0] w_idx = tail_q - PTR_W'(g + 1);
        assign ent[g]       = mem_q[w_idx];
        assign ent_valid[g] = (CNT_W'(g) < count_q);
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : write_buffer
//  Description : Posted-write buffer between the CPU memory port and memory.
//                Stores are absorbed into a FIFO and drained one per cycle
//                while idle; loads forward the newest matching buffered
//                store or stall through a fixed-latency memory read.
//                clock, reset : clock / synchronous active-high reset
//                bus (slave)  : CPU request/response, memory port, status
//  Revision    : 1.0  initial release
// ============================================================================
module write_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH    = c_DEPTH_DEFAULT,
    parameter int READ_LAT = c_READ_LAT_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    write_buffer_if.slave   bus
);
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    wb_state_t              state_q, state_d;
    logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;

    logic                   push, pop, full, empty;
    wb_entry_t              push_entry, head_entry;
    logic [DEPTH-1:0]       ent_valid;
    wb_entry_t [DEPTH-1:0]  ent;
    logic [$clog2(DEPTH):0] count;

    logic                   load_req, store_req, hit;
    logic [31:0]            hit_data;

    write_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .ent_valid  (ent_valid),
        .ent        (ent),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    assign load_req   = bus.cpu_req & ~bus.cpu_wr;
    assign store_req  = bus.cpu_req &  bus.cpu_wr;
    assign push_entry = '{addr: bus.cpu_addr[31:2], data: bus.cpu_wdata};

    // Forwarding search: scan oldest-to-newest so the newest match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent[i].addr == bus.cpu_addr[31:2])) begin
                hit      = 1'b1;
                hit_data = ent[i].data;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        push          = 1'b0;
        pop           = 1'b0;
        bus.cpu_stall = 1'b0;
        bus.cpu_rdata = '0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (load_req && !hit) begin
                    // Address goes out in the request cycle so that the data
                    // arrives exactly when lat_cnt reaches zero.
                    state_d       = RD_WAIT;
                    lat_cnt_d     = LAT_W'(READ_LAT - 1);
                    bus.cpu_stall = 1'b1;
                    bus.mem_addr  = bus.cpu_addr;
                end else begin
                    if (load_req) begin
                        bus.cpu_rdata = hit_data;
                    end
                    // Full blocks the store even if a pop happens this cycle.
                    if (store_req) begin
                        if (full) begin
                            bus.cpu_stall = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                    if (!empty) begin
                        pop           = 1'b1;
                        bus.mem_wr    = 1'b1;
                        bus.mem_addr  = {head_entry.addr, 2'b00};
                        bus.mem_wdata = head_entry.data;
                    end
                end
            end
            RD_WAIT: begin
                bus.mem_addr = bus.cpu_addr;
                if (lat_cnt_q == '0) begin
                    bus.cpu_rdata = bus.mem_rdata;
                    state_d       = IDLE;
                end else begin
                    bus.cpu_stall = 1'b1;
                    lat_cnt_d     = lat_cnt_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign bus.wb_empty = empty;
    assign bus.wb_count = count;

endmodule
`default_nettype wire
